// File: rtl/game_flow_controller_if.sv
// Bus between the game flow controller and the rest of the Frogger top:
// player/datapath inputs in, session flags and display values out.
interface game_flow_controller_if;
    logic       i_Start;
    logic       i_Has_Collided;
    logic       i_Level_Up;
    logic       o_Game_Active;
    logic       o_Cars_Freeze;
    logic       o_Frog_Reset;
    logic       o_Game_Over;
    logic [1:0] o_Lives;
    logic [3:0] o_Level;
    logic [6:0] o_Time_Left;
    logic [2:0] o_State;

    modport master (
        output i_Start, i_Has_Collided, i_Level_Up,
        input  o_Game_Active, o_Cars_Freeze, o_Frog_Reset, o_Game_Over,
        input  o_Lives, o_Level, o_Time_Left, o_State
    );

    modport slave (
        input  i_Start, i_Has_Collided, i_Level_Up,
        output o_Game_Active, o_Cars_Freeze, o_Frog_Reset, o_Game_Over,
        output o_Lives, o_Level, o_Time_Left, o_State
    );
endinterface

// File: rtl/game_flow_controller.sv
// Frogger session sequencer: countdown, round timer, lives, hit/level-clear
// freezes and game over, driving the frog gate and car freeze.
module game_flow_controller #(
    parameter int C_LIVES_INI     = 3,
    parameter int C_CLKS_PER_SEC  = 25_000_000,
    parameter int C_ROUND_TIME    = 60,
    parameter int C_START_DELAY   = 25_000_000,
    parameter int C_FREEZE_CYCLES = 25_000_000
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    game_flow_controller_if.slave       bus
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_COUNTDOWN   = 3'd1,
        S_RUNNING     = 3'd2,
        S_HIT         = 3'd3,
        S_LEVEL_CLEAR = 3'd4,
        S_GAME_OVER   = 3'd5
    } t_State;

    localparam logic [1:0]  C_LIVES_LOAD = 2'(C_LIVES_INI);
    localparam logic [6:0]  C_TIME_LOAD  = 7'(C_ROUND_TIME);
    localparam logic [31:0] C_START_LAST = 32'(C_START_DELAY - 1);
    localparam logic [31:0] C_FRZ_LAST   = 32'(C_FREEZE_CYCLES - 1);
    localparam logic [31:0] C_SEC_LAST   = 32'(C_CLKS_PER_SEC - 1);

    t_State      r_State;
    t_State      w_Next_State;
    logic        r_Start_Q;
    logic        r_Frog_Reset;
    logic [1:0]  r_Lives,    w_Next_Lives;
    logic [3:0]  r_Level,    w_Next_Level;
    logic [6:0]  r_Time,     w_Next_Time;
    logic [31:0] r_Count,    w_Next_Count;
    logic [31:0] r_Prescale, w_Next_Prescale;
    logic        w_Start_Edge;
    logic        w_Wrap;
    logic        w_Timeout;
    logic        w_Frog_Reset_Next;

    assign w_Start_Edge = bus.i_Start & ~r_Start_Q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State      <= S_IDLE;
            r_Start_Q    <= 1'b0;
            r_Frog_Reset <= 1'b0;
            r_Lives      <= 2'd0;
            r_Level      <= 4'd0;
            r_Time       <= 7'd0;
            r_Count      <= 32'd0;
            r_Prescale   <= 32'd0;
        end else begin
            r_State      <= w_Next_State;
            r_Start_Q    <= bus.i_Start;
            r_Frog_Reset <= w_Frog_Reset_Next;
            r_Lives      <= w_Next_Lives;
            r_Level      <= w_Next_Level;
            r_Time       <= w_Next_Time;
            r_Count      <= w_Next_Count;
            r_Prescale   <= w_Next_Prescale;
        end
    end

    // Collision outranks timeout, which outranks level-up; all three are only
    // seen while RUNNING, so one life is lost even if collision and timeout coincide.
    always_comb begin
        w_Next_State    = r_State;
        w_Next_Lives    = r_Lives;
        w_Next_Level    = r_Level;
        w_Next_Time     = r_Time;
        w_Next_Count    = r_Count + 32'd1;
        w_Next_Prescale = r_Prescale;
        w_Wrap          = 1'b0;
        w_Timeout       = 1'b0;

        case (r_State)
            S_IDLE, S_GAME_OVER: begin
                w_Next_Count = 32'd0;
                if (r_State == S_GAME_OVER) begin
                    w_Next_Lives = 2'd0;
                end
                if (w_Start_Edge) begin
                    w_Next_Lives = C_LIVES_LOAD;
                    w_Next_Level = 4'd1;
                    w_Next_Time  = C_TIME_LOAD;
                    w_Next_State = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                w_Next_Prescale = 32'd0;
                if (r_Count == C_START_LAST) begin
                    w_Next_State = S_RUNNING;
                end
            end
            S_RUNNING: begin
                w_Next_Count    = 32'd0;
                w_Wrap          = (r_Prescale == C_SEC_LAST);
                w_Next_Prescale = w_Wrap ? 32'd0 : r_Prescale + 32'd1;
                w_Timeout       = w_Wrap && (r_Time == 7'd1);
                if (w_Wrap && (r_Time != 7'd0)) begin
                    w_Next_Time = r_Time - 7'd1;
                end
                if (bus.i_Has_Collided || w_Timeout) begin
                    if (r_Lives != 2'd0) begin
                        w_Next_Lives = r_Lives - 2'd1;
                    end
                    w_Next_State = (r_Lives <= 2'd1) ? S_GAME_OVER : S_HIT;
                end else if (bus.i_Level_Up) begin
                    if (r_Level != 4'd15) begin
                        w_Next_Level = r_Level + 4'd1;
                    end
                    w_Next_Time  = C_TIME_LOAD;
                    w_Next_State = S_LEVEL_CLEAR;
                end
            end
            S_HIT: begin
                if (r_Count == C_FRZ_LAST) begin
                    w_Next_Time  = C_TIME_LOAD;
                    w_Next_State = S_COUNTDOWN;
                end
            end
            S_LEVEL_CLEAR: begin
                if (r_Count == C_FRZ_LAST) begin
                    w_Next_State = S_COUNTDOWN;
                end
            end
            default: begin
                w_Next_State = S_IDLE;
            end
        endcase

        if (w_Next_State != r_State) begin
            w_Next_Count = 32'd0;
        end
    end

    assign w_Frog_Reset_Next = (w_Next_State == S_COUNTDOWN) && (r_State != S_COUNTDOWN);

    assign bus.o_Game_Active = (r_State == S_RUNNING);
    assign bus.o_Cars_Freeze = (r_State == S_HIT) || (r_State == S_LEVEL_CLEAR) ||
                               (r_State == S_GAME_OVER);
    assign bus.o_Game_Over   = (r_State == S_GAME_OVER);
    assign bus.o_Frog_Reset  = r_Frog_Reset;
    assign bus.o_Lives       = r_Lives;
    assign bus.o_Level       = r_Level;
    assign bus.o_Time_Left   = r_Time;
    assign bus.o_State       = r_State;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: directed session steps plus a
// randomized phase, all compared each cycle against a cycle-count session model.
module tb_game_flow_controller;

    localparam int LIVES  = 3;
    localparam int CLKS   = 10;
    localparam int ROUND  = 3;
    localparam int START  = 4;
    localparam int FREEZE = 6;

    localparam int M_IDLE = 0;
    localparam int M_CD   = 1;
    localparam int M_RUN  = 2;
    localparam int M_HIT  = 3;
    localparam int M_LC   = 4;
    localparam int M_GO   = 5;

    logic clk;
    logic rst_n;
    int   passCount  = 0;
    int   totalCount = 0;

    // Session model: phase, remaining cycles in the timed phase, cycles to next second
    int   mMode;
    int   mLives;
    int   mLevel;
    int   mTime;
    int   mLeft;
    int   mTick;
    bit   mFrogReset;
    bit   mPrevStart;

    game_flow_controller_if bus ();

    game_flow_controller #(
        .C_LIVES_INI     (LIVES),
        .C_CLKS_PER_SEC  (CLKS),
        .C_ROUND_TIME    (ROUND),
        .C_START_DELAY   (START),
        .C_FREEZE_CYCLES (FREEZE)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        mMode = M_IDLE; mLives = 0; mLevel = 0; mTime = 0;
        mLeft = 0; mTick = 0; mFrogReset = 0; mPrevStart = 0;
    endtask

    task automatic modelStep(input bit s, input bit c, input bit l);
        bit startEdge;
        bit timeout;
        startEdge  = s && !mPrevStart;
        mPrevStart = s;
        mFrogReset = 0;
        timeout    = 0;
        case (mMode)
            M_IDLE, M_GO: begin
                if (startEdge) begin
                    mLives = LIVES; mLevel = 1; mTime = ROUND;
                    mMode = M_CD; mLeft = START; mFrogReset = 1;
                end
            end
            M_CD: begin
                mLeft--;
                if (mLeft == 0) begin
                    mMode = M_RUN; mTick = CLKS;
                end
            end
            M_RUN: begin
                mTick--;
                if (mTick == 0) begin
                    mTick = CLKS;
                    if (mTime > 0) begin
                        timeout = (mTime == 1);
                        mTime--;
                    end
                end
                if (c || timeout) begin
                    if (mLives > 0) mLives--;
                    mMode = (mLives == 0) ? M_GO : M_HIT;
                    mLeft = FREEZE;
                end else if (l) begin
                    if (mLevel < 15) mLevel++;
                    mTime = ROUND; mMode = M_LC; mLeft = FREEZE;
                end
            end
            M_HIT: begin
                mLeft--;
                if (mLeft == 0) begin
                    mTime = ROUND; mMode = M_CD; mLeft = START; mFrogReset = 1;
                end
            end
            M_LC: begin
                mLeft--;
                if (mLeft == 0) begin
                    mMode = M_CD; mLeft = START; mFrogReset = 1;
                end
            end
            default: mMode = M_IDLE;
        endcase
    endtask

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic checkOutput();
        checkValue("game_active", 8'(bus.o_Game_Active), 8'(mMode == M_RUN));
        checkValue("cars_freeze", 8'(bus.o_Cars_Freeze),
                   8'((mMode == M_HIT) || (mMode == M_LC) || (mMode == M_GO)));
        checkValue("game_over",   8'(bus.o_Game_Over),   8'(mMode == M_GO));
        checkValue("frog_reset",  8'(bus.o_Frog_Reset),  8'(mFrogReset));
        checkValue("lives",       8'(bus.o_Lives),       8'(mLives));
        checkValue("level",       8'(bus.o_Level),       8'(mLevel));
        checkValue("time_left",   8'(bus.o_Time_Left),   8'(mTime));
        checkValue("state",       8'(bus.o_State),       8'(mMode));
    endtask

    task automatic applyStimulus(input bit s, input bit c, input bit l);
        bus.i_Start        = s;
        bus.i_Has_Collided = c;
        bus.i_Level_Up     = l;
        @(posedge clk);
        modelStep(s, c, l);
        #1;
        checkOutput();
    endtask

    task automatic waitForMode(input int target, input int bound);
        int n;
        n = 0;
        while ((mMode != target) && (n < bound)) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            n++;
        end
        checkValue("wait_state", 8'(bus.o_State), 8'(target));
    endtask

    initial begin
        bit s;
        rst_n              = 1'b0;
        bus.i_Start        = 1'b0;
        bus.i_Has_Collided = 1'b0;
        bus.i_Level_Up     = 1'b0;
        modelReset();
        #12;
        checkOutput();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("[TB] reset released");

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

        // Start edge then hold start high: no retrigger, timeouts cost lives
        repeat (100) applyStimulus(1'b1, 1'b0, 1'b0);
        waitForMode(M_GO, 200);

        // Fresh session; collision and level-up together -> HIT, level unchanged
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitForMode(M_RUN, 20);
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
        waitForMode(M_CD, 20);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Remaining collisions down to game over, then restart
        waitForMode(M_RUN, 20);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitForMode(M_RUN, 20);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Collision on the very cycle the timer expires
        waitForMode(M_RUN, 20);
        for (int n = 0; n < 40 && !(mTime == 1 && mTick == 1); n++)
            applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("pre_timeout_time", 8'(bus.o_Time_Left), 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Sixteen level-ups: level saturates at 15
        for (int k = 0; k < 16; k++) begin
            waitForMode(M_RUN, 40);
            applyStimulus(1'b0, 1'b0, 1'b1);
        end
        waitForMode(M_RUN, 40);
        checkValue("level_saturated", 8'(bus.o_Level), 8'd15);

        // Asynchronous reset in the middle of a clock period
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        #3;
        rst_n = 1'b1;
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);

        // Randomized play
        s = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) s = ~s;
            applyStimulus(s, ($urandom_range(0, 29) == 0), ($urandom_range(0, 11) == 0));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
